// File: rtl/fifo_slave_pkg.sv
// Register map, field positions and reset helpers for the FIFO slave.
package fifo_slave_pkg;

  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_THRESH = 3'd3;
  localparam logic [2:0] OFF_ERR    = 3'd4;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_CNT_LSB = 2;
  localparam int ST_CNT_MSB = 10;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_IRQEN = 1;

  localparam int CW = 9;

  function automatic logic [CW-1:0] thresh_rst(input int depth);
    return CW'(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage with wrapping pointers, occupancy count and flush.
module fifo_mem
  import fifo_slave_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Power-of-two depth lets the pointers wrap on their own.
  always_comb begin
    wptr_d  = wptr_q + PW'(do_push);
    rptr_d  = rptr_q + PW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fifo_slave.sv
// Bus-mapped FIFO slave: DATA/STATUS/CTRL/THRESH/ERR registers.
// Interrupt logic is built only when FIFO_SLAVE_IRQ_EN is defined.
module fifo_slave
  import fifo_slave_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 64,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_sel,
  input  logic          s_wr,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_din,
  output logic [DW-1:0] s_dout,
  output logic          irq
);

  logic [2:0]    off;
  logic          wr, rd;
  logic          push, pop, flush;
  logic [DW-1:0] head;
  logic          full, empty;
  logic [CW-1:0] count;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] dout_q, rd_val;
  logic [CW-1:0] thresh_v;
  logic          irq_en_v;
  logic          unused_ok;

  assign unused_ok = ^{s_addr, s_din};

  assign off   = s_addr[2:0];
  assign wr    = s_sel & s_wr & ~reset;
  assign rd    = s_sel & ~s_wr & ~reset;
  assign push  = wr & (off == OFF_DATA);
  assign pop   = rd & (off == OFF_DATA);
  assign flush = wr & (off == OFF_CTRL) & s_din[CTRL_FLUSH];

  fifo_mem #(.DEPTH(DEPTH), .DW(DW)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (s_din),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // A set in the same cycle as a clear wins.
  always_comb begin
    err_d = err_q;
    if (wr && off == OFF_ERR) err_d = err_d & ~s_din[1:0];
    if (push && full)  err_d[ERR_OVF] = 1'b1;
    if (pop && empty)  err_d[ERR_UDF] = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_DATA:   rd_val = empty ? '0 : head;
      OFF_STATUS: begin
        rd_val[ST_CNT_MSB:ST_CNT_LSB] = count;
        rd_val[ST_FULL]  = full;
        rd_val[ST_EMPTY] = empty;
      end
      OFF_CTRL:   rd_val[CTRL_IRQEN] = irq_en_v;
      OFF_THRESH: rd_val[CW-1:0] = thresh_v;
      OFF_ERR:    rd_val[1:0] = err_q;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q  <= '0;
      dout_q <= '0;
    end else begin
      err_q <= err_d;
      if (rd) dout_q <= rd_val;
    end
  end

  assign s_dout = dout_q;

`ifdef FIFO_SLAVE_IRQ_EN
  logic [CW-1:0] thresh_q;
  logic          irq_en_q;
  logic          irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      thresh_q <= thresh_rst(DEPTH);
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr && off == OFF_THRESH) thresh_q <= s_din[CW-1:0];
      if (wr && off == OFF_CTRL)   irq_en_q <= s_din[CTRL_IRQEN];
      irq_q <= irq_en_q & ((count >= thresh_q) | (|err_q));
    end
  end

  assign thresh_v = thresh_q;
  assign irq_en_v = irq_en_q;
  assign irq      = irq_q;
`else
  assign thresh_v = '0;
  assign irq_en_v = 1'b0;
  assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_slave.sv
// Directed self-checking bench for fifo_slave (DEPTH=8, DW=64).
module tb_fifo_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_sel;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [63:0] d;

  always #5 clk = ~clk;

  fifo_slave #(.DEPTH(8), .DW(64), .AW(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_sel  (s_sel),
    .s_wr   (s_wr),
    .s_addr (s_addr),
    .s_din  (s_din),
    .s_dout (s_dout),
    .irq    (irq)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [63:0] v);
    s_sel = 1'b1; s_wr = 1'b1;
    s_addr = {13'd0, off}; s_din = v;
    @(posedge clk); #1;
    s_sel = 1'b0; s_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, output logic [63:0] v);
    s_sel = 1'b1; s_wr = 1'b0;
    s_addr = {13'd0, off};
    @(posedge clk); #1;
    v = s_dout;
    s_sel = 1'b0;
  endtask

  initial begin
`ifdef FIFO_SLAVE_IRQ_EN
    logic [63:0] thr_rst = 64'd8;
    logic [63:0] irq_on  = 64'd1;
    logic [63:0] ctrl_en = 64'h2;
`else
    logic [63:0] thr_rst = 64'd0;
    logic [63:0] irq_on  = 64'd0;
    logic [63:0] ctrl_en = 64'h0;
`endif
    reset = 1'b1; s_sel = 1'b0; s_wr = 1'b0;
    s_addr = '0; s_din = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_dout", s_dout, 64'h0);
    chk("rst_irq", {63'd0, irq}, 64'h0);
    rd(3'd1, d); chk("rst_status", d, 64'h1);
    rd(3'd3, d); chk("rst_thresh", d, thr_rst);
    rd(3'd4, d); chk("rst_err", d, 64'h0);

    // push / pop
    wr(3'd0, 64'h1111_1111_1111_1111);
    wr(3'd0, 64'hffff_ffff_ffff_ffff);
    rd(3'd1, d); chk("status_2", d, 64'h8);
    rd(3'd0, d); chk("pop_1111", d, 64'h1111_1111_1111_1111);
    idle();      chk("dout_hold", s_dout, 64'h1111_1111_1111_1111);
    rd(3'd0, d); chk("pop_ffff", d, 64'hffff_ffff_ffff_ffff);
    rd(3'd1, d); chk("status_empty", d, 64'h1);
    rd(3'd5, d); chk("off5_zero", d, 64'h0);

    // full / overflow
    for (int i = 0; i < 9; i++) wr(3'd0, 64'h100 + 64'(i));
    rd(3'd1, d); chk("status_full", d, 64'h22);
    rd(3'd4, d); chk("err_ovf", d, 64'h1);
    wr(3'd4, 64'h1);
    rd(3'd4, d); chk("err_ovf_clr", d, 64'h0);
    for (int i = 0; i < 8; i++) begin
      rd(3'd0, d); chk("full_pop", d, 64'h100 + 64'(i));
    end

    // underflow
    rd(3'd0, d); chk("udf_data", d, 64'h0);
    rd(3'd4, d); chk("err_udf", d, 64'h2);
    wr(3'd4, 64'h2);
    rd(3'd4, d); chk("err_udf_clr", d, 64'h0);

    // wrap-around
    for (int i = 0; i < 6; i++) wr(3'd0, 64'h55 + 64'(i));
    for (int i = 0; i < 6; i++) begin
      rd(3'd0, d); chk("wrap_pre", d, 64'h55 + 64'(i));
    end
    for (int i = 0; i < 6; i++)
      wr(3'd0, 64'hdead_dead_dead_0000 + 64'(i));
    for (int i = 0; i < 6; i++) begin
      rd(3'd0, d); chk("wrap_pop", d, 64'hdead_dead_dead_0000 + 64'(i));
    end

    // irq threshold
    wr(3'd2, 64'h2);
    wr(3'd3, 64'h3);
    rd(3'd2, d); chk("ctrl_rd", d, ctrl_en);
    wr(3'd0, 64'h1);
    wr(3'd0, 64'h2);
    idle(); chk("irq_below", {63'd0, irq}, 64'h0);
    wr(3'd0, 64'h3);
    idle(); chk("irq_at_thr", {63'd0, irq}, irq_on);
    rd(3'd0, d);
    idle(); chk("irq_drop", {63'd0, irq}, 64'h0);
    rd(3'd0, d); rd(3'd0, d);

    // flush and reset
    for (int i = 0; i < 4; i++) wr(3'd0, 64'h70 + 64'(i));
    wr(3'd2, 64'h1);
    rd(3'd1, d); chk("flush_status", d, 64'h1);
    rd(3'd2, d); chk("flush_ctrl", d, 64'h0);
    wr(3'd0, 64'haa); wr(3'd0, 64'hbb);
    rd(3'd1, d); chk("pre_rst_status", d, 64'h8);
    reset = 1'b1;
    wr(3'd0, 64'hcc);
    reset = 1'b0;
    chk("rst2_dout", s_dout, 64'h0);
    rd(3'd1, d); chk("rst2_status", d, 64'h1);
    rd(3'd4, d); chk("rst2_err", d, 64'h0);
    rd(3'd3, d); chk("rst2_thresh", d, thr_rst);
    chk("rst2_irq", {63'd0, irq}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_slave.md
FIFO_SLAVE -- requirements
Module: fifo_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter DW, default 64, data width matching bus data.
REQ-003 SHALL have parameter AW, default 16, bus address width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_sel  input  1  slave select from bus decoder.
REQ-007 SHALL have port s_wr  input  1  1 = write, 0 = read; qualified by s_sel.
REQ-008 SHALL have port s_addr  input  AW  byte-independent word address; only s_addr[2:0] decoded.
REQ-009 SHALL have port s_din  input  DW  write data from bus.
REQ-010 SHALL have port s_dout  output  DW  registered read data to bus.
REQ-011 SHALL have port irq  output  1  level interrupt, registered.

Function
REQ-012 SHALL decode offsets: 0 DATA, 1 STATUS, 2 CTRL, 3 THRESH, 4 ERR; offsets 5-7 read 0, writes ignored.
REQ-013 SHALL, on write to DATA when not full, push s_din; count increments next cycle.
REQ-014 SHALL, on read of DATA when not empty, pop head entry; s_dout holds it the cycle after the access.
REQ-015 SHALL provide read latency of exactly 1 cycle for all offsets; s_dout holds last value when s_sel=0.
REQ-016 SHALL format STATUS as {zeros, count[8:0] at bits 10:2, full bit1, empty bit0}.
REQ-017 SHALL, on write to DATA when full, drop data, leave pointers unchanged, set ERR[0] overflow.
REQ-018 SHALL, on read of DATA when empty, return 0, leave pointers unchanged, set ERR[1] underflow.
REQ-019 SHALL treat ERR as sticky; write 1 to a bit clears it; set in the same cycle as clear wins.
REQ-020 SHALL use CTRL bit0 flush: write 1 empties FIFO next cycle, self-clears, reads 0; bit1 irq_en read/write.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-022 SHALL assert irq the cycle after irq_en=1 and (count>=THRESH or ERR!=0), deassert likewise.
REQ-023 SHALL use THRESH[8:0] read/write; upper bits read 0; THRESH=0 with irq_en asserts irq unconditionally.
REQ-024 SHALL perform at most one access per cycle; a flush write has priority over any pending state.

Reset
REQ-025 SHALL, while reset=1 at a clock edge, clear pointers, count, ERR, CTRL, s_dout, and irq to 0, and set THRESH to DEPTH.
REQ-026 SHALL discard an access coincident with reset; FIFO contents need not be cleared.
REQ-027 SHALL report STATUS = 0x1 (empty) on the first read after reset.

Configuration
REQ-028 SHALL, with FIFO_SLAVE_IRQ_EN defined, implement THRESH, irq_en, and irq as above.
REQ-029 SHALL, without FIFO_SLAVE_IRQ_EN, tie irq to 0, read THRESH and CTRL bit1 as 0, and ignore their writes.

Structure
REQ-030 SHALL place offset constants, STATUS/ERR/CTRL bit positions, and the reset THRESH in package fifo_slave_pkg.
REQ-031 SHALL implement storage and pointer/count logic in sub-module fifo_mem (push, pop, flush, full, empty, count).
REQ-032 SHALL keep register decode, ERR, CTRL, and irq in fifo_slave.

Verification
REQ-033 SHALL cover push/pop: reset; write DATA 0x1111_1111_1111_1111 then 0xffff_ffff_ffff_ffff; read DATA twice -> s_dout 0x1111...,0xffff... each 1 cycle later; STATUS 0x1.
REQ-034 SHALL cover full/overflow: 9 writes at DEPTH=8 -> STATUS 0x22 (count 8, full); ERR 0x1; ninth data never read back.
REQ-035 SHALL cover underflow: read DATA empty -> s_dout 0; ERR 0x2; write ERR 0x2 -> ERR 0x0.
REQ-036 SHALL cover wrap-around: 6 pushes, 6 pops, 6 pushes of 0xdead_dead_dead_0000+i -> pops return i=0..5 in order.
REQ-037 SHALL cover irq: irq_en=1, THRESH=3; third push -> irq high next cycle; one pop -> irq low next cycle; repeat without macro -> irq stays 0.
REQ-038 SHALL cover flush/reset: 4 pushes, CTRL=0x1 -> STATUS 0x1; 2 pushes then reset=1 one cycle -> STATUS 0x1, ERR 0, THRESH 8.
